// File: rtl/exe_cmd_issuer_pkg.sv
// Shared encodings for the issue stage: ALU opcodes, ARM opcodes, condition
// codes, status-register flag positions and the issued command record.
package exe_cmd_issuer_pkg;

   localparam logic [3:0] EXE_MOV = 4'b0001;
   localparam logic [3:0] EXE_MVN = 4'b1001;
   localparam logic [3:0] EXE_ADD = 4'b0010;
   localparam logic [3:0] EXE_ADC = 4'b0011;
   localparam logic [3:0] EXE_SUB = 4'b0100;
   localparam logic [3:0] EXE_SBC = 4'b0101;
   localparam logic [3:0] EXE_AND = 4'b0110;
   localparam logic [3:0] EXE_ORR = 4'b0111;
   localparam logic [3:0] EXE_EOR = 4'b1000;
   localparam logic [3:0] EXE_MEM = 4'b0010;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam int FLAG_N = 31;
   localparam int FLAG_Z = 30;
   localparam int FLAG_C = 29;
   localparam int FLAG_V = 28;

   typedef struct packed {
      logic [3:0]  exe_command;
      logic        s_bit;
      logic        wb_en;
      logic        mem_read;
      logic        mem_write;
      logic        imm;
      logic [11:0] shift_operand;
      logic [3:0]  rn;
      logic [3:0]  rd;
   } cmd_t;

endpackage

// File: rtl/exe_cmd_issuer_cond_check.sv
// ARM condition-code evaluator against {N,Z,C,V}; purely combinational so the
// branch unit can reuse it.
module exe_cmd_issuer_cond_check
   import exe_cmd_issuer_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic n, z, c, v;
   assign {n, z, c, v} = flags;

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/exe_cmd_issuer.sv
// Issue stage: decodes ARM-style words, checks conditions against the ALU's
// returned flags and hands one registered command per cycle to execute.
module exe_cmd_issuer
   import exe_cmd_issuer_pkg::*;
#(
   parameter int PEND_W = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic        flush,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [3:0]  exe_command,
   output logic        s_bit,
   output logic        wb_en,
   output logic        mem_read,
   output logic        mem_write,
   output logic        imm,
   output logic [11:0] shift_operand,
   output logic [3:0]  rn,
   output logic [3:0]  rd,
   output logic        illegal,
   input  logic        status_wr,
   input  logic [3:0]  status_bits,
   output logic [31:0] status_reg_out
);

   localparam logic [PEND_W:0] PEND_MAX = {1'b0, {PEND_W{1'b1}}};

   logic [3:0]        flags;
   logic [PEND_W-1:0] pending;
   logic [PEND_W:0]   in_flight;
   cmd_t              cmd_q, dec;
   logic              cmd_valid_q, illegal_q;
   logic              dec_legal, cond_pass, held_s, hazard, stall;
   logic              load, hs, inc, dec_p;

   exe_cmd_issuer_cond_check u_cond_check (
      .cond  (instr[31:28]),
      .flags (flags),
      .pass  (cond_pass)
   );

   always_comb begin
      dec               = '0;
      dec_legal         = 1'b0;
      dec.imm           = instr[25];
      dec.shift_operand = instr[11:0];
      dec.rn            = instr[19:16];
      dec.rd            = instr[15:12];
      if (instr[27:26] == 2'b00) begin
         dec_legal = 1'b1;
         dec.wb_en = 1'b1;
         dec.s_bit = instr[20];
         case (instr[24:21])
            OP_MOV:  dec.exe_command = EXE_MOV;
            OP_MVN:  dec.exe_command = EXE_MVN;
            OP_ADD:  dec.exe_command = EXE_ADD;
            OP_ADC:  dec.exe_command = EXE_ADC;
            OP_SUB:  dec.exe_command = EXE_SUB;
            OP_SBC:  dec.exe_command = EXE_SBC;
            OP_AND:  dec.exe_command = EXE_AND;
            OP_ORR:  dec.exe_command = EXE_ORR;
            OP_EOR:  dec.exe_command = EXE_EOR;
            OP_CMP: begin
               dec.exe_command = EXE_SUB;
               dec.wb_en       = 1'b0;
               dec.s_bit       = 1'b1;
            end
            OP_TST: begin
               dec.exe_command = EXE_AND;
               dec.wb_en       = 1'b0;
               dec.s_bit       = 1'b1;
            end
            default: begin
               dec_legal = 1'b0;
               dec.wb_en = 1'b0;
               dec.s_bit = 1'b0;
            end
         endcase
      end else if (instr[27:26] == 2'b01) begin
         dec_legal       = 1'b1;
         dec.exe_command = EXE_MEM;
         dec.mem_read    = instr[20];
         dec.wb_en       = instr[20];
         dec.mem_write   = !instr[20];
      end
   end

   // The held S command counts toward the limit too, otherwise its handshake
   // could push pending past the counter's range.
   assign held_s    = cmd_valid_q && cmd_q.s_bit;
   assign in_flight = {1'b0, pending} + {{PEND_W{1'b0}}, held_s};
   assign hazard    = (pending != '0) || held_s;
   assign stall     = ((instr[31:28] != COND_AL) && hazard) ||
                      (dec.s_bit && (in_flight >= PEND_MAX));

   // Valid/ready: a word moves on a cycle where instr_valid && instr_ready, a
   // command moves where cmd_valid && cmd_ready; cmd_valid never drops unaccepted
   // except on flush or reset.
   assign instr_ready = rst_n && instr_valid && !flush && !stall &&
                        (!cmd_valid_q || cmd_ready);
   assign load  = instr_ready && dec_legal && cond_pass;
   assign hs    = cmd_valid_q && cmd_ready;
   assign inc   = hs && cmd_q.s_bit;
   assign dec_p = status_wr && (pending != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags       <= '0;
         pending     <= '0;
         cmd_valid_q <= 1'b0;
         cmd_q       <= '0;
         illegal_q   <= 1'b0;
      end else begin
         if (status_wr) flags <= status_bits;
         if (inc && !dec_p)      pending <= pending + 1'b1;
         else if (dec_p && !inc) pending <= pending - 1'b1;
         illegal_q <= instr_ready && !dec_legal;
         if (flush)     cmd_valid_q <= 1'b0;
         else if (load) cmd_valid_q <= 1'b1;
         else if (hs)   cmd_valid_q <= 1'b0;
         if (load) cmd_q <= dec;
      end
   end

   assign cmd_valid     = cmd_valid_q;
   assign illegal       = illegal_q;
   assign exe_command   = cmd_q.exe_command;
   assign s_bit         = cmd_q.s_bit;
   assign wb_en         = cmd_q.wb_en;
   assign mem_read      = cmd_q.mem_read;
   assign mem_write     = cmd_q.mem_write;
   assign imm           = cmd_q.imm;
   assign shift_operand = cmd_q.shift_operand;
   assign rn            = cmd_q.rn;
   assign rd            = cmd_q.rd;

   always_comb begin
      status_reg_out         = '0;
      status_reg_out[FLAG_N] = flags[3];
      status_reg_out[FLAG_Z] = flags[2];
      status_reg_out[FLAG_C] = flags[1];
      status_reg_out[FLAG_V] = flags[0];
   end

endmodule

// File: tb/tb_exe_cmd_issuer.sv
// Directed bench for exe_cmd_issuer: decode vector table plus hand-written
// sequences for stalls, back-pressure, pending limits, flush and reset.
module tb_exe_cmd_issuer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        instr_valid, instr_ready, flush, cmd_valid, cmd_ready;
   logic [3:0]  exe_command, rn, rd, status_bits;
   logic        s_bit, wb_en, mem_read, mem_write, imm, illegal, status_wr;
   logic [11:0] shift_operand;
   logic [31:0] status_reg_out;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [31:0] I_ADDS  = 32'hE0921003;
   localparam logic [31:0] I_MOV   = 32'hE3A00005;
   localparam logic [31:0] I_MOVEQ = 32'h03A00005;
   localparam logic [31:0] I_MOVMI = 32'h43A00005;
   localparam logic [31:0] I_CMP   = 32'hE1510002;
   localparam logic [31:0] I_TST   = 32'hE1110002;
   localparam logic [31:0] I_LDR   = 32'hE5954008;

   exe_cmd_issuer #(.PEND_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .flush(flush), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .exe_command(exe_command), .s_bit(s_bit),
      .wb_en(wb_en), .mem_read(mem_read), .mem_write(mem_write), .imm(imm),
      .shift_operand(shift_operand), .rn(rn), .rd(rd), .illegal(illegal),
      .status_wr(status_wr), .status_bits(status_bits),
      .status_reg_out(status_reg_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic        v;
      logic        ill;
      logic [3:0]  cmd;
      logic        s, wb, mr, mw, im;
      logic [3:0]  rn, rd;
      logic [11:0] so;
   } vec_t;

   vec_t vecs[17];

   function automatic logic [31:0] fields();
      return {3'b0, exe_command, s_bit, wb_en, mem_read, mem_write, imm, rn, rd, shift_operand};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_vec(input vec_t t, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      instr = t.instr; instr_valid = 1'b1; cmd_ready = 1'b1;
      #1 chk({tag, "_ready"}, {31'b0, instr_ready}, 32'd1);
      tick();
      instr_valid = 1'b0;
      chk({tag, "_valid"}, {31'b0, cmd_valid}, {31'b0, t.v});
      chk({tag, "_illegal"}, {31'b0, illegal}, {31'b0, t.ill});
      if (t.v)
         chk({tag, "_fields"}, fields(),
             {3'b0, t.cmd, t.s, t.wb, t.mr, t.mw, t.im, t.rn, t.rd, t.so});
      tick();
      chk({tag, "_ill_clr"}, {31'b0, illegal}, 32'd0);
      chk({tag, "_drain"}, {31'b0, cmd_valid}, 32'd0);
      status_wr = 1'b1; status_bits = 4'b0000;
      tick();
      status_wr = 1'b0;
   endtask

   initial begin
      //                instr         v  il cmd    s  wb mr mw im rn    rd    so
      vecs[0]  = '{32'hE0921003, 1, 0, 4'h2, 1, 1, 0, 0, 0, 4'h2, 4'h1, 12'h003};
      vecs[1]  = '{32'hE3A00005, 1, 0, 4'h1, 0, 1, 0, 0, 1, 4'h0, 4'h0, 12'h005};
      vecs[2]  = '{32'hE3E00000, 1, 0, 4'h9, 0, 1, 0, 0, 1, 4'h0, 4'h0, 12'h000};
      vecs[3]  = '{32'hE0443005, 1, 0, 4'h4, 0, 1, 0, 0, 0, 4'h4, 4'h3, 12'h005};
      vecs[4]  = '{32'hE0112003, 1, 0, 4'h6, 1, 1, 0, 0, 0, 4'h1, 4'h2, 12'h003};
      vecs[5]  = '{32'hE1800000, 1, 0, 4'h7, 0, 1, 0, 0, 0, 4'h0, 4'h0, 12'h000};
      vecs[6]  = '{32'hE0200000, 1, 0, 4'h8, 0, 1, 0, 0, 0, 4'h0, 4'h0, 12'h000};
      vecs[7]  = '{32'hE0A00000, 1, 0, 4'h3, 0, 1, 0, 0, 0, 4'h0, 4'h0, 12'h000};
      vecs[8]  = '{32'hE0C00000, 1, 0, 4'h5, 0, 1, 0, 0, 0, 4'h0, 4'h0, 12'h000};
      vecs[9]  = '{32'hE1510002, 1, 0, 4'h4, 1, 0, 0, 0, 0, 4'h1, 4'h0, 12'h002};
      vecs[10] = '{32'hE1110002, 1, 0, 4'h6, 1, 0, 0, 0, 0, 4'h1, 4'h0, 12'h002};
      vecs[11] = '{32'hE5954008, 1, 0, 4'h2, 0, 1, 1, 0, 0, 4'h5, 4'h4, 12'h008};
      vecs[12] = '{32'hE5854008, 1, 0, 4'h2, 0, 0, 0, 1, 0, 4'h5, 4'h4, 12'h008};
      vecs[13] = '{32'hEA000000, 0, 1, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 12'h000};
      vecs[14] = '{32'hF3A00005, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 12'h000};
      vecs[15] = '{32'hE0600000, 0, 1, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 12'h000};
      vecs[16] = '{32'hEE000000, 0, 1, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 12'h000};

      rst_n = 1'b0; instr = '0; instr_valid = 1'b0; flush = 1'b0;
      cmd_ready = 1'b0; status_wr = 1'b0; status_bits = '0;
      #12;
      chk("rst_valid", {31'b0, cmd_valid}, 32'd0);
      chk("rst_illegal", {31'b0, illegal}, 32'd0);
      chk("rst_fields", fields(), 32'd0);
      chk("rst_status", status_reg_out, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_ready", {31'b0, instr_ready}, 32'd0);

      for (int i = 0; i < 17; i++) apply_vec(vecs[i], i);

      // Pending limit: CMP, TST, CMP issue back-to-back; the fourth waits.
      cmd_ready = 1'b1; instr_valid = 1'b1;
      instr = I_CMP; #1 chk("lim_rdy0", {31'b0, instr_ready}, 32'd1); tick();
      instr = I_TST; #1 chk("lim_rdy1", {31'b0, instr_ready}, 32'd1); tick();
      instr = I_CMP; #1 chk("lim_rdy2", {31'b0, instr_ready}, 32'd1); tick();
      instr = I_TST; #1 chk("lim_rdy3", {31'b0, instr_ready}, 32'd0); tick();
      chk("lim_rdy4", {31'b0, instr_ready}, 32'd0);
      chk("lim_cv4", {31'b0, cmd_valid}, 32'd0);
      status_wr = 1'b1; status_bits = 4'b0000;
      #1 chk("lim_rdy5", {31'b0, instr_ready}, 32'd0); tick();
      status_wr = 1'b0;
      #1 chk("lim_rdy6", {31'b0, instr_ready}, 32'd1); tick();
      instr_valid = 1'b0; status_wr = 1'b1;
      #1 chk("lim_cv7", {31'b0, cmd_valid}, 32'd1); tick();
      status_wr = 1'b0; instr_valid = 1'b1; instr = I_CMP;
      #1 chk("lim_rdy8", {31'b0, instr_ready}, 32'd1); tick();
      instr = I_TST;
      #1 chk("lim_rdy9", {31'b0, instr_ready}, 32'd0); tick();
      instr_valid = 1'b0; status_wr = 1'b1; status_bits = 4'b1010;
      repeat (4) tick();
      status_wr = 1'b0;
      chk("lim_flags", status_reg_out, 32'hA000_0000);

      // Flush drops a held S command without touching pending.
      cmd_ready = 1'b0; instr = I_ADDS; instr_valid = 1'b1;
      #1 chk("fl_rdy0", {31'b0, instr_ready}, 32'd1); tick();
      instr = I_MOV; flush = 1'b1;
      #1 chk("fl_rdy_flush", {31'b0, instr_ready}, 32'd0);
      chk("fl_cv_held", {31'b0, cmd_valid}, 32'd1); tick();
      flush = 1'b0;
      chk("fl_cv_clr", {31'b0, cmd_valid}, 32'd0);
      instr = I_MOVMI; cmd_ready = 1'b1;
      #1 chk("fl_rdy_mi", {31'b0, instr_ready}, 32'd1); tick();
      instr_valid = 1'b0;
      chk("fl_cv_mi", {31'b0, cmd_valid}, 32'd1);
      chk("fl_cmd_mi", {28'b0, exe_command}, 32'd1); tick();

      // ADDS then MOVEQ: stall until flags return with Z set.
      instr = I_ADDS; instr_valid = 1'b1;
      #1 chk("eq_rdy0", {31'b0, instr_ready}, 32'd1); tick();
      instr = I_MOVEQ;
      #1 chk("eq_rdy1", {31'b0, instr_ready}, 32'd0); tick();
      chk("eq_rdy2", {31'b0, instr_ready}, 32'd0);
      chk("eq_cv2", {31'b0, cmd_valid}, 32'd0); tick();
      status_wr = 1'b1; status_bits = 4'b0100;
      #1 chk("eq_rdy3", {31'b0, instr_ready}, 32'd0); tick();
      status_wr = 1'b0;
      chk("eq_flags", status_reg_out, 32'h4000_0000);
      #1 chk("eq_rdy4", {31'b0, instr_ready}, 32'd1); tick();
      instr_valid = 1'b0;
      chk("eq_cv", {31'b0, cmd_valid}, 32'd1);
      chk("eq_fields", fields(), {3'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 12'h005});
      tick();
      // Same pair with Z clear: MOVEQ is consumed and dropped.
      instr = I_ADDS; instr_valid = 1'b1; #1 tick();
      instr_valid = 1'b0; tick();
      status_wr = 1'b1; status_bits = 4'b0000; tick();
      status_wr = 1'b0; instr = I_MOVEQ; instr_valid = 1'b1;
      #1 chk("ne_rdy", {31'b0, instr_ready}, 32'd1); tick();
      instr_valid = 1'b0;
      chk("ne_cv", {31'b0, cmd_valid}, 32'd0);
      chk("ne_illegal", {31'b0, illegal}, 32'd0);

      // LDR held under back-pressure; next word accepted as cmd_ready rises.
      cmd_ready = 1'b0; instr = I_LDR; instr_valid = 1'b1;
      #1 chk("bp_rdy0", {31'b0, instr_ready}, 32'd1); tick();
      instr = I_MOV;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp_cv%0d", k), {31'b0, cmd_valid}, 32'd1);
         chk($sformatf("bp_fields%0d", k), fields(),
             {3'b0, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 4'h4, 12'h008});
         chk($sformatf("bp_rdy%0d", k), {31'b0, instr_ready}, 32'd0);
         tick();
      end
      cmd_ready = 1'b1;
      #1 chk("bp_rdy_rise", {31'b0, instr_ready}, 32'd1); tick();
      instr_valid = 1'b0;
      chk("bp_cv_next", {31'b0, cmd_valid}, 32'd1);
      chk("bp_cmd_next", {28'b0, exe_command}, 32'd1); tick();

      // Reset in the middle of a stall.
      status_wr = 1'b1; status_bits = 4'b1111; tick();
      status_wr = 1'b0; cmd_ready = 1'b0; instr = I_ADDS; instr_valid = 1'b1;
      #1 tick();
      instr = I_MOVEQ;
      #1 chk("rs_rdy_stall", {31'b0, instr_ready}, 32'd0);
      rst_n = 1'b0;
      #1 chk("rs_cv", {31'b0, cmd_valid}, 32'd0);
      chk("rs_status", status_reg_out, 32'd0);
      chk("rs_fields", fields(), 32'd0);
      chk("rs_illegal", {31'b0, illegal}, 32'd0);
      chk("rs_rdy", {31'b0, instr_ready}, 32'd0);
      tick(); tick();
      rst_n = 1'b1; instr_valid = 1'b0;
      #1 chk("rs_rdy_novalid", {31'b0, instr_ready}, 32'd0);
      instr_valid = 1'b1;
      #1 chk("rs_rdy_valid", {31'b0, instr_ready}, 32'd1); tick();
      instr_valid = 1'b0;
      chk("rs_cv_after", {31'b0, cmd_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
